pipe_chain: RTL and testbench

PIPE_CHAIN -- requirements
Module: pipe_chain

---
 rtl/pipe_chain_pkg.sv | 14 +
 rtl/pipe_chain_stage.sv | 38 +++
 rtl/pipe_chain.sv | 105 ++++++++++
 tb/tb_pipe_chain.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_chain_pkg.sv
// Shared limits and helpers for the pipe_chain register pipeline.
//   MAX_DEPTH / MAX_WIDTH : supported parameter ranges
//   occ_width()           : width of the optional occupancy count
package pipe_chain_pkg;

    localparam int unsigned MAX_DEPTH = 16;
    localparam int unsigned MAX_WIDTH = 64;

    // Bits needed to count 0..depth set valid bits; never narrower than 1.
    function automatic int unsigned occ_width(input int unsigned depth);
        return (depth == 0) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_chain_stage.sv
// One pipeline slot: valid bit plus data word.
// Ports:
//   CLK, reset  : clock, asynchronous active-high reset (clears v and d)
//   clr         : synchronous clear of the valid bit (flush)
//   en          : slot accepts a new value this cycle (empty or draining)
//   v_in, d_in  : incoming valid/data from the upstream slot
//   v_out, d_out: registered slot contents
module pipe_chain_stage
    import pipe_chain_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             v_out,
    output logic [WIDTH-1:0] d_out
);

    // Data only loads with a valid word so an emptied slot keeps its last value.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            v_out <= 1'b0;
            d_out <= '0;
        end else if (clr) begin
            v_out <= 1'b0;
        end else if (en) begin
            v_out <= v_in;
            if (v_in) begin
                d_out <= d_in;
            end
        end
    end

endmodule

// File: rtl/pipe_chain.sv
// Valid/ready register pipeline of DEPTH slots with bubble collapse.
// Ports:
//   CLK, reset          : clock, asynchronous active-high reset
//   flush               : synchronous clear of all in-flight words
//   in_valid, in_ready  : upstream handshake (in_ready combinational from out_ready)
//   DATA_IN             : upstream data
//   out_valid, out_ready: downstream handshake
//   DATA_OUT            : last-slot data
//   occupancy           : number of occupied slots (only with PIPE_CHAIN_OCCUPANCY_EN)
// DEPTH=0 degenerates to wires.
module pipe_chain
    import pipe_chain_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] DATA_IN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] DATA_OUT
`ifdef PIPE_CHAIN_OCCUPANCY_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

    if (DEPTH == 0) begin : g_comb
        // Pass-through; no state, so clock and reset are intentionally unused.
        logic unused_clk_rst;
        assign unused_clk_rst = CLK ^ reset;

        assign DATA_OUT  = DATA_IN;
        assign out_valid = in_valid & ~flush;
        assign in_ready  = out_ready & ~flush;
`ifdef PIPE_CHAIN_OCCUPANCY_EN
        assign occupancy = '0;
`endif
    end else begin : g_pipe
        logic [DEPTH-1:0] v;
        logic [DEPTH-1:0] acc;
        logic [DEPTH-1:0] fwd;
        logic [WIDTH-1:0] d [DEPTH];
        logic             go;

        // Ready ripples from the output side: a slot accepts when it is empty
        // or everything downstream of it is moving. acc[i] = !v[i] || adv[i].
        always_comb begin
            acc = '0;
            fwd = '0;
            go  = out_ready & ~flush;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                go     = ~v[i] | go;
                acc[i] = go;
            end
            in_ready = ~flush & go;
            // Word entering each slot: input handshake for slot 0, otherwise
            // the upstream slot advancing into it.
            fwd[0] = in_valid & in_ready;
            for (int i = 1; i < DEPTH; i++) begin
                fwd[i] = v[i-1] & acc[i];
            end
        end

        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic [WIDTH-1:0] din;
            if (i == 0) begin : g_first
                assign din = DATA_IN;
            end else begin : g_rest
                assign din = d[i-1];
            end

            pipe_chain_stage #(.WIDTH(WIDTH)) u_stage (
                .CLK   (CLK),
                .reset (reset),
                .clr   (flush),
                .en    (acc[i]),
                .v_in  (fwd[i]),
                .d_in  (din),
                .v_out (v[i]),
                .d_out (d[i])
            );
        end

        assign out_valid = v[DEPTH-1];
        assign DATA_OUT  = d[DEPTH-1];

`ifdef PIPE_CHAIN_OCCUPANCY_EN
        localparam int unsigned OCC_W = occ_width(DEPTH);

        // Population count of the registered valid bits.
        always_comb begin
            occupancy = '0;
            for (int i = 0; i < DEPTH; i++) begin
                occupancy = occupancy + OCC_W'(v[i]);
            end
        end
`endif
    end

endmodule

// File: tb/tb_pipe_chain.sv
// Bench for pipe_chain: DEPTH=3 and DEPTH=4 instances share one stimulus and
// are tracked by a word/position model; a DEPTH=0 WIDTH=16 instance is driven
// separately. Occupancy is checked when PIPE_CHAIN_OCCUPANCY_EN is defined.
module tb_pipe_chain;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       reset, flush, in_valid, out_ready;
    logic [7:0] din;
    logic       ir3, ov3, ir4, ov4;
    logic [7:0] do3, do4;
    logic       fl0, iv0, or0, ir0, ov0;
    logic [15:0] di0, do0;
`ifdef PIPE_CHAIN_OCCUPANCY_EN
    logic [1:0] occ3;
    logic [2:0] occ4;
    logic       occ0;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] seen [$];

    pipe_chain #(.WIDTH(8), .DEPTH(3)) dut3 (
        .CLK(CLK), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir3),
        .DATA_IN(din), .out_valid(ov3), .out_ready(out_ready), .DATA_OUT(do3)
`ifdef PIPE_CHAIN_OCCUPANCY_EN
        , .occupancy(occ3)
`endif
    );

    pipe_chain #(.WIDTH(8), .DEPTH(4)) dut4 (
        .CLK(CLK), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir4),
        .DATA_IN(din), .out_valid(ov4), .out_ready(out_ready), .DATA_OUT(do4)
`ifdef PIPE_CHAIN_OCCUPANCY_EN
        , .occupancy(occ4)
`endif
    );

    pipe_chain #(.WIDTH(16), .DEPTH(0)) dut0 (
        .CLK(CLK), .reset(reset), .flush(fl0), .in_valid(iv0), .in_ready(ir0),
        .DATA_IN(di0), .out_valid(ov0), .out_ready(or0), .DATA_OUT(do0)
`ifdef PIPE_CHAIN_OCCUPANCY_EN
        , .occupancy(occ0)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per pipeline, the in-flight words oldest first with their slot index.
    int         mpos [2][16];
    logic [7:0] mdat [2][16];
    int         mcnt [2] = '{0, 0};

    function automatic int dep(input int idx);
        return (idx == 0) ? 3 : 4;
    endfunction

    // Each word moves one slot forward unless blocked by the slot its
    // predecessor ends up in; the oldest leaves from the last slot on out_ready.
    // Returns the highest slot left free at the input side (-1: input blocked).
    function automatic int step_model(input int idx, input logic ordy, input logic fl,
                                      input logic iv, input logic [7:0] dv, input bit commit);
        int         lim;
        int         n;
        int         np;
        int         tpos [16];
        logic [7:0] tdat [16];
        lim = dep(idx) - 1;
        n   = 0;
        for (int k = 0; k < mcnt[idx]; k++) begin
            if (k == 0 && mpos[idx][k] == dep(idx) - 1 && ordy && !fl) continue;
            np      = (mpos[idx][k] + 1 > lim) ? lim : mpos[idx][k] + 1;
            tpos[n] = np;
            tdat[n] = mdat[idx][k];
            n++;
            lim = np - 1;
        end
        if (commit) begin
            if (fl) begin
                mcnt[idx] = 0;
            end else begin
                for (int k = 0; k < n; k++) begin
                    mpos[idx][k] = tpos[k];
                    mdat[idx][k] = tdat[k];
                end
                if (iv && lim >= 0) begin
                    mpos[idx][n] = 0;
                    mdat[idx][n] = dv;
                    n++;
                end
                mcnt[idx] = n;
            end
        end
        return lim;
    endfunction

    function automatic logic exp_ov(input int idx);
        return (mcnt[idx] > 0) && (mpos[idx][0] == dep(idx) - 1);
    endfunction

    always @(posedge CLK or posedge reset) begin
        if (reset) begin
            mcnt[0] = 0;
            mcnt[1] = 0;
        end else begin
            void'(step_model(0, out_ready, flush, in_valid, din, 1'b1));
            void'(step_model(1, out_ready, flush, in_valid, din, 1'b1));
        end
    end

    // Compare DUT outputs to the model away from the active edge.
    always @(negedge CLK) begin
        int l3;
        int l4;
        l3 = step_model(0, out_ready, flush, in_valid, din, 1'b0);
        l4 = step_model(1, out_ready, flush, in_valid, din, 1'b0);
        check("m3_in_ready", 64'(ir3), 64'(!flush && l3 >= 0));
        check("m3_out_valid", 64'(ov3), 64'(exp_ov(0)));
        if (exp_ov(0)) check("m3_data_out", 64'(do3), 64'(mdat[0][0]));
        check("m4_in_ready", 64'(ir4), 64'(!flush && l4 >= 0));
        check("m4_out_valid", 64'(ov4), 64'(exp_ov(1)));
        if (exp_ov(1)) check("m4_data_out", 64'(do4), 64'(mdat[1][0]));
`ifdef PIPE_CHAIN_OCCUPANCY_EN
        check("m3_occupancy", 64'(occ3), 64'(mcnt[0]));
        check("m4_occupancy", 64'(occ4), 64'(mcnt[1]));
`endif
        if (ov3 && out_ready && !flush) seen.push_back(do3);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;
        fl0 = 1'b0; iv0 = 1'b0; or0 = 1'b0; di0 = '0;

        // Reset state
        #1 reset = 1'b1;
        #1;
        check("rst_out_valid", 64'(ov3), 64'h0);
        check("rst_data_out", 64'(do3), 64'h0);
        check("rst_in_ready", 64'(ir3), 64'h1);
        flush = 1'b1;
        #1;
        check("rst_flush_in_ready", 64'(ir3), 64'h0);
        flush = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Back-to-back 0x11,0x22,0x33 with out_ready high: 3-cycle latency
        seen.delete();
        out_ready = 1'b1; in_valid = 1'b1; din = 8'h11; tick();
        din = 8'h22; tick();
        check("lat_c2_out_valid", 64'(ov3), 64'h0);
        din = 8'h33; tick();
        in_valid = 1'b0;
        check("lat_c3_out_valid", 64'(ov3), 64'h1);
        check("lat_c3_data", 64'(do3), 64'h11);
        tick();
        check("lat_c4_data", 64'(do3), 64'h22);
        tick();
        check("lat_c5_data", 64'(do3), 64'h33);
        tick();
        check("lat_c6_out_valid", 64'(ov3), 64'h0);
        repeat (3) tick();
        check("lat_seen_count", 64'(seen.size()), 64'd3);
        if (seen.size() == 3) begin
            check("lat_seen0", 64'(seen[0]), 64'h11);
            check("lat_seen2", 64'(seen[2]), 64'h33);
        end

        // Stall with out_ready low, then release: 5 words in order
        seen.delete();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int w = 1; w <= 3; w++) begin
            din = 8'(w);
            check("stall_accept", 64'(ir3), 64'h1);
            tick();
        end
        din = 8'd4;
        check("stall_full_in_ready", 64'(ir3), 64'h0);
        tick(); tick();
        check("stall_hold_in_ready", 64'(ir3), 64'h0);
        out_ready = 1'b1;
        #1;
        check("full_same_cycle_in_ready", 64'(ir3), 64'h1);
        tick();
        din = 8'd5;
        guard = 0;
        while (!ir3 && guard < 10) begin
            tick();
            guard++;
        end
        check("stall_w5_wait", 64'(guard < 10), 64'h1);
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        check("stall_seen_count", 64'(seen.size()), 64'd5);
        for (int k = 0; k < 5 && k < seen.size(); k++) begin
            check("stall_seen_order", 64'(seen[k]), 64'(k + 1));
        end

        // Single 0xA5 collapses to the last slot and holds while stalled
        out_ready = 1'b0; in_valid = 1'b1; din = 8'hA5; tick();
        in_valid = 1'b0; tick();
        check("hold_c2_out_valid", 64'(ov3), 64'h0);
        tick();
        check("hold_c3_out_valid", 64'(ov3), 64'h1);
        check("hold_c3_data", 64'(do3), 64'hA5);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_stable_valid", 64'(ov3), 64'h1);
            check("hold_stable_data", 64'(do3), 64'hA5);
        end
        out_ready = 1'b1; tick();
        check("hold_release", 64'(ov3), 64'h0);
        repeat (3) tick();

        // Flush with two words in flight and in_valid high (DEPTH=4)
        in_valid = 1'b1; din = 8'hC1; tick();
        din = 8'hC2; tick();
        flush = 1'b1; din = 8'h77;
        #1;
        check("flush_in_ready4", 64'(ir4), 64'h0);
        check("flush_in_ready3", 64'(ir3), 64'h0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid4", 64'(ov4), 64'h0);
`ifdef PIPE_CHAIN_OCCUPANCY_EN
        check("flush_occupancy4", 64'(occ4), 64'h0);
`endif
        repeat (4) tick();
        check("flush_no_ghost4", 64'(ov4), 64'h0);

        // Flush while a word is at the output: out_valid still shown, then cleared
        in_valid = 1'b1; din = 8'hE1; tick();
        in_valid = 1'b0; tick(); tick();
        check("flush_out_pre", 64'(ov3), 64'h1);
        flush = 1'b1;
        #1;
        check("flush_out_during", 64'(ov3), 64'h1);
        tick();
        flush = 1'b0;
        check("flush_out_after", 64'(ov3), 64'h0);
        repeat (3) tick();

        // Asynchronous reset between edges
        out_ready = 1'b0; in_valid = 1'b1; din = 8'h3C; tick();
        din = 8'h4D; tick();
        in_valid = 1'b0; tick();
        check("arst_pre_valid", 64'(ov3), 64'h1);
        check("arst_pre_data", 64'(do3), 64'h3C);
        #1 reset = 1'b1;
        #1;
        check("arst_out_valid", 64'(ov3), 64'h0);
        check("arst_data_out", 64'(do3), 64'h0);
        check("arst_in_ready", 64'(ir3), 64'h1);
        reset = 1'b0;
        tick();
        out_ready = 1'b1; in_valid = 1'b1; din = 8'h5A; tick();
        din = 8'h6B; tick();
        in_valid = 1'b0; tick();
        check("post_rst_first", 64'(do3), 64'h5A);
        check("post_rst_valid", 64'(ov3), 64'h1);
        tick();
        check("post_rst_second", 64'(do3), 64'h6B);
        repeat (3) tick();

        // DEPTH=0 pass-through
        iv0 = 1'b1; di0 = 16'hBEEF;
        for (int k = 0; k < 4; k++) begin
            or0 = k[0];
            #1;
            check("d0_data", 64'(do0), 64'hBEEF);
            check("d0_out_valid", 64'(ov0), 64'h1);
            check("d0_in_ready", 64'(ir0), 64'(k % 2));
        end
        fl0 = 1'b1;
        #1;
        check("d0_flush_valid", 64'(ov0), 64'h0);
        check("d0_flush_ready", 64'(ir0), 64'h0);
        fl0 = 1'b0; iv0 = 1'b0;
        #1;
        check("d0_idle_valid", 64'(ov0), 64'h0);
`ifdef PIPE_CHAIN_OCCUPANCY_EN
        check("d0_occupancy", 64'(occ0), 64'h0);
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
